seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Multicycle signed divider, restoring algorithm, one quotient bit per clock.
- Sits beside the register bank and ALU in the multicycle datapath. It replaces the combinational divider feeding the HI/LO registers.
- Acts as the responder to the control FSM's start/done handshake: the control unit requests a DIV, waits in a hold state, then writes HI/LO.
- Also reports division by zero to the exception logic.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W = WIDTH.

Ports:
- clk       input   1      rising-edge clock
- reset     input   1      asynchronous, active-high reset
- start     input   1      request a division; sampled only in IDLE
- dividend  input   WIDTH  signed dividend (A register); captured at the start edge
- divisor   input   WIDTH  signed divisor (B register); captured at the start edge
- busy      output  1      high from the start edge until done deasserts
- done      output  1      one-cycle pulse: results are valid, or divide-by-zero was detected
- by_zero   output  1      high together with done when the captured divisor was 0
- hi        output  WIDTH  remainder (goes to the HI register)
- lo        output  WIDTH  quotient (goes to the LO register)

Behaviour:
- Reset (asynchronous, active-high, any state, including mid-division):
  - state goes to IDLE; busy, done, by_zero, hi, lo all go to 0.
  - Iteration counter and internal remainder/quotient shift registers are cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 with divisor!=0 (edge E0): capture |dividend| and |divisor| as unsigned WIDTH-bit values, latch sign bits, clear counter and partial remainder, go to RUN, busy=1.
  - start=1 with divisor==0 (edge E0): go to DONE with by_zero=1 and done=1 visible after E0. busy=1 for that one cycle. hi and lo keep their previous values.
- RUN, one iteration per edge (E1..E32):
  - Shift {rem,quo} left by 1; trial = rem - |divisor|.
  - If trial is non-negative: rem = trial and quo LSB = 1. Otherwise restore and quo LSB = 0.
  - Counter increments; after the iteration at count = WIDTH-1, go to FIX.
- FIX (edge E33):
  - lo = quo, negated if sign(dividend) XOR sign(divisor).
  - hi = rem, negated if sign(dividend) (truncating semantics: remainder takes the dividend's sign).
  - Go to DONE with done=1.
- DONE (one cycle): done=1; by_zero holds its value. Next edge: done=0, by_zero=0, busy=0, state IDLE.
- Latency:
  - Non-zero divisor: done is high in the single cycle after E33, i.e. 33 edges after the start-sampling edge.
  - Zero divisor: done is high in the cycle after E0.
- hi/lo hold their last results indefinitely. They change only in FIX or on reset, never during RUN.
- start while busy (RUN/FIX/DONE) is ignored. There is no queuing and no restart.
- dividend/divisor changes after E0 have no effect.
- A new start may be sampled on the edge at which DONE returns to IDLE? No: start is sampled only while the state is IDLE, so back-to-back operations need at least one IDLE cycle.
- Overflow: -2^31 / -1 gives lo=0x80000000, hi=0. This is wrap-around with no flag, which is the correct result of unsigned magnitude arithmetic truncated to WIDTH.
- All arithmetic is WIDTH+1 bits internally for the trial subtraction. Magnitudes are unsigned WIDTH bits, so |−2^31| = 0x80000000 is exact.

Test Plan:
- 100 / 7: start one cycle -> done one cycle later at edge E0+33; lo=14, hi=2, by_zero=0, busy low the cycle after done.
- -100 / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). 100 / -7 -> lo=-14, hi=2. -100 / -7 -> lo=14, hi=-2.
- 5 / 0 with prior hi=0x11, lo=0x22 -> done and by_zero high in the cycle after E0; hi=0x11, lo=0x22 unchanged; no RUN cycles.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, by_zero=0. Also 3 / 10 -> lo=0, hi=3.
- Start 1000/3, pulse start again at E10, change dividend to 0 at E5 -> single done at E0+33 with lo=333, hi=1; second start ignored.
- Assert reset at E16 of a RUN -> busy, done, hi, lo immediately 0 (asynchronous, before the next edge), state IDLE. A fresh 9/2 afterwards gives lo=4, hi=1.

Source files
------------

// File: rtl/seq_div_if.sv
// Handshake and operand/result bundle between the control FSM and the divider.
interface seq_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, dividend, divisor,
                  input  busy, done, by_zero, hi, lo);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, by_zero, hi, lo);
endinterface

// File: rtl/seq_div.sv
// Multicycle signed restoring divider: one quotient bit per clock; quotient to LO, remainder to HI.
//   state | meaning
//   IDLE  | waiting for start; hi/lo hold last result
//   RUN   | one restoring iteration per edge on magnitudes
//   FIX   | apply signs and load hi/lo
//   DONE  | one-cycle done pulse (by_zero set if divisor was 0)
module seq_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic    clk,
  input  logic    reset,
  seq_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bz_q, bz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
    end
  end

  // Extra top bit keeps the trial subtraction exact for a 2^(WIDTH-1) divisor.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            bz_d    = 1'b1;
            state_d = DONE;
          end else begin
            sa_d    = bus.dividend[WIDTH-1];
            sb_d    = bus.divisor[WIDTH-1];
            quo_d   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
            dvs_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
        hi_d    = sa_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: begin
        bz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.by_zero = bz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_seq_div.sv
// Directed vector bench for seq_div: latency, signed results, divide-by-zero, ignored restart, async reset.
module tb_seq_div;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_div_if #(.WIDTH(32)) bus ();
  seq_div #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        bz;
    string       tag;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one start, waits for done (bounded), checks results and the cycle after done.
  task automatic run_op(input vec_t t);
    int n;
    logic seen;
    bus.start    = 1'b1;
    bus.dividend = t.a;
    bus.divisor  = t.b;
    tick();
    bus.start = 1'b0;
    chk({t.tag, " busy after start"}, 32'(bus.busy), 32'd1);
    n    = 0;
    seen = bus.done;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (n == 16) begin
        chk({t.tag, " hi stable in run"}, bus.hi, cur_hi);
        chk({t.tag, " lo stable in run"}, bus.lo, cur_lo);
      end
      seen = bus.done;
    end
    chk({t.tag, " done seen"}, 32'(seen), 32'd1);
    chk({t.tag, " latency"}, 32'(n), t.bz ? 32'd0 : 32'd33);
    chk({t.tag, " lo"}, bus.lo, t.lo);
    chk({t.tag, " hi"}, bus.hi, t.hi);
    chk({t.tag, " by_zero"}, 32'(bus.by_zero), 32'(t.bz));
    chk({t.tag, " busy with done"}, 32'(bus.busy), 32'd1);
    tick();
    chk({t.tag, " done cleared"}, 32'(bus.done), 32'd0);
    chk({t.tag, " busy cleared"}, 32'(bus.busy), 32'd0);
    chk({t.tag, " by_zero cleared"}, 32'(bus.by_zero), 32'd0);
    cur_hi = t.hi;
    cur_lo = t.lo;
  endtask

  initial begin
    int n;
    int dones;
    vec_t t;

    vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, "100/7"};
    vecs[1]  = '{32'(-100),    32'd7,          32'(-14),       32'(-2),        1'b0, "-100/7"};
    vecs[2]  = '{32'd100,      32'(-7),        32'(-14),       32'd2,          1'b0, "100/-7"};
    vecs[3]  = '{32'(-100),    32'(-7),        32'd14,         32'(-2),        1'b0, "-100/-7"};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          1'b0, "min/-1"};
    vecs[5]  = '{32'd3,        32'd10,         32'd0,          32'd3,          1'b0, "3/10"};
    vecs[6]  = '{32'h451,      32'h20,         32'h22,         32'h11,         1'b0, "0x451/0x20"};
    vecs[7]  = '{32'd5,        32'd0,          32'h22,         32'h11,         1'b1, "5/0"};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF,  32'd0,          1'b0, "max/1"};
    vecs[9]  = '{32'h8000_0000, 32'd2,         32'hC000_0000,  32'd0,          1'b0, "min/2"};
    vecs[10] = '{32'(-7),      32'h8000_0000,  32'd0,          32'hFFFF_FFF9,  1'b0, "-7/min"};
    vecs[11] = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, "0/5"};

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 32'h0;
    bus.divisor  = 32'h0;
    #2 reset = 1'b1;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset by_zero", 32'(bus.by_zero), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i]);
    end

    // Restart attempt and operand change during RUN must be ignored.
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    tick();
    bus.start = 1'b0;
    n     = 0;
    dones = 0;
    while (n < 80) begin
      tick();
      n++;
      if (n == 5)  bus.dividend = 32'd0;
      if (n == 10) bus.start = 1'b1;
      if (n == 11) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          chk("1000/3 latency", 32'(n), 32'd33);
          chk("1000/3 lo", bus.lo, 32'd333);
          chk("1000/3 hi", bus.hi, 32'd1);
        end
      end
    end
    chk("1000/3 single done", 32'(dones), 32'd1);
    chk("1000/3 idle after", 32'(bus.busy), 32'd0);
    cur_hi = 32'd1;
    cur_lo = 32'd333;

    // Asynchronous reset in the middle of RUN.
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset hi", bus.hi, 32'd0);
    chk("midreset lo", bus.lo, 32'd0);
    #1 reset = 1'b0;
    tick();
    chk("post reset idle", 32'(bus.busy), 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    t = '{32'd9, 32'd2, 32'd4, 32'd1, 1'b0, "9/2 after reset"};
    run_op(t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
